speed_detector: RTL and testbench
=================================

Name: speed_detector

Overview:
- Receiver-side counterpart of the speed timer. Takes a divided square-wave speed clock (1/2/4/8 Hz from a 50 MHz system clock) and recovers the 2-bit speed code that produced it.
- Measures each half-period in system clocks, classifies it against four nominal half-periods, and confirms over consecutive measurements before reporting.
- Sits on the consumer side of the speed clock, e.g. a checker or a remote board that has no access to the speed switches.

Parameters:
- HP0, 25000001, nominal half-period in clk cycles for code 2'b00 (1 Hz)
- HP1, 12500001, nominal half-period for code 2'b01 (2 Hz)
- HP2, 6250001, nominal half-period for code 2'b10 (4 Hz)
- HP3, 3125001, nominal half-period for code 2'b11 (8 Hz)
- TOL, 65536, accepted deviation in cycles; match means |N-HPk| <= TOL; windows must not overlap
- CONFIRM, 2, consecutive same-class measurements required to lock (1..15)
- TIMEOUT, 30000000, cycles without an edge before declaring stall; must exceed HP0+TOL

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-high reset
- spd_clk  input  1  divided speed clock, asynchronous to clk
- spe_out  output  2  recovered speed code, held between updates
- locked  output  1  1 = spe_out confirmed and current
- meas_valid  output  1  one-cycle pulse, new half_period available
- half_period  output  32  last measured half-period in clk cycles
- err  output  1  one-cycle pulse, measurement matched no class
- stall  output  1  1 = no edge within TIMEOUT

Behaviour:
- Interface: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0. Internal state: FSM in SEEK, counter 0, candidate 0, match count 0.
- Input path: spd_clk passes through a 2-FF synchronizer, then a registered previous value.
  - An edge is detected when synced != previous. Both rising and falling edges count.
- FSM states:
  - SEEK: counter idle. On edge, go to MEAS with counter=1. No meas_valid on this first edge.
  - MEAS: counter increments each cycle.
    - On edge: N = counter value. Go to MEAS with counter=1.
    - If counter reaches TIMEOUT with no edge: go to SEEK and set stall=1.
- Measurement timing: if edges are detected at cycles t and t+N, then at cycle t+N+1:
  - meas_valid=1 and half_period=N.
  - Classification result is applied in the same cycle.
- Classification: check k=0..3 for |N-HPk| <= TOL. Use 32-bit unsigned compares with no wrap; compute as N>=HPk-TOL and N<=HPk+TOL.
- Match to class k:
  - If k == candidate and match count > 0: increment match count, saturating at CONFIRM.
  - Otherwise: candidate=k, match count=1.
  - When match count reaches CONFIRM: spe_out=candidate and locked=1, in the same cycle as meas_valid.
  - With CONFIRM=1, the first valid measurement locks.
- Lock changes:
  - Locked, and a matched class differs from spe_out: locked drops to 0 immediately. spe_out holds until the new class is confirmed.
- No match:
  - err=1 for one cycle, alongside meas_valid.
  - match count=0, locked=0, spe_out held.
- Timeout:
  - locked=0, stall=1, match count=0, spe_out held.
  - stall clears in the cycle after the next detected edge, which also restarts measurement from SEEK.
- Simultaneous events: an edge in the same cycle the counter reaches TIMEOUT is treated as an edge, not a timeout.
- Counter saturates at TIMEOUT and never wraps.
- Reset mid-measurement: everything returns to reset values at once, and any partial count is discarded.

Test Plan:
Bench parameters: HP0=100, HP1=50, HP2=25, HP3=12, TOL=2, CONFIRM=2, TIMEOUT=200.
- spd_clk toggling every 50 clk:
  - First edge gives no meas_valid.
  - Next two edges give half_period=50.
  - locked=1 and spe_out=01 on the second meas_valid.
- Locked at 01, switch toggle interval to 12:
  - First 12-cycle measurement drops locked to 0, spe_out stays 01.
  - Second measurement gives spe_out=11, locked=1.
- Toggle interval 98 then 102 (edges of tolerance window): lock at 00. Interval 97: err pulse, locked=0.
- Locked at 10, hold spd_clk constant:
  - stall=1 and locked=0 exactly 200 cycles after the last counted edge.
  - Resume toggling every 25: stall clears after the first edge, lock is regained after two more edges.
- Toggle interval 37 (between classes): err pulse on every meas_valid, locked stays 0, spe_out stays 00 from reset.
- Assert rst mid-measurement while locked at 11: all outputs 0 immediately. After release, the first edge produces no meas_valid.

Source files
------------

// File: rtl/speed_detector_if.sv
// Speed-clock link between a speed clock source and the speed detector.
// The detector consumes spd_clk and publishes the recovered code and measurement status.
interface speed_detector_if;
    logic        spd_clk;
    logic [1:0]  spe_out;
    logic        locked;
    logic        meas_valid;
    logic [31:0] half_period;
    logic        err;
    logic        stall;

    modport master (
        output spd_clk,
        input  spe_out,
        input  locked,
        input  meas_valid,
        input  half_period,
        input  err,
        input  stall
    );

    modport slave (
        input  spd_clk,
        output spe_out,
        output locked,
        output meas_valid,
        output half_period,
        output err,
        output stall
    );
endinterface

// File: rtl/speed_detector.sv
// Recovers the 2-bit speed code from a divided square-wave speed clock by timing
// each half-period in clk cycles, classifying it, and confirming over repeated matches.
module speed_detector #(
    parameter int unsigned HP0     = 25000001,
    parameter int unsigned HP1     = 12500001,
    parameter int unsigned HP2     = 6250001,
    parameter int unsigned HP3     = 3125001,
    parameter int unsigned TOL     = 65536,
    parameter int unsigned CONFIRM = 2,
    parameter int unsigned TIMEOUT = 30000000
) (
    input  logic             clk,
    input  logic             rst,
    speed_detector_if.slave  bus
);

    typedef enum logic {
        SEEK = 1'b0,
        MEAS = 1'b1
    } state_t;

    // Window bounds clamp at zero so a small HPk never wraps the lower limit.
    localparam logic [31:0] LO0 = (HP0 > TOL) ? 32'(HP0 - TOL) : 32'd0;
    localparam logic [31:0] LO1 = (HP1 > TOL) ? 32'(HP1 - TOL) : 32'd0;
    localparam logic [31:0] LO2 = (HP2 > TOL) ? 32'(HP2 - TOL) : 32'd0;
    localparam logic [31:0] LO3 = (HP3 > TOL) ? 32'(HP3 - TOL) : 32'd0;
    localparam logic [31:0] HI0 = 32'(HP0 + TOL);
    localparam logic [31:0] HI1 = 32'(HP1 + TOL);
    localparam logic [31:0] HI2 = 32'(HP2 + TOL);
    localparam logic [31:0] HI3 = 32'(HP3 + TOL);
    localparam logic [31:0] TMO = 32'(TIMEOUT);
    localparam logic [3:0]  CONF = 4'(CONFIRM);

    state_t      state_q;
    logic        sync1_q;
    logic        sync2_q;
    logic        prev_q;
    logic [31:0] count_q;
    logic [1:0]  cand_q;
    logic [3:0]  match_cnt_q;

    logic [1:0]  spe_q;
    logic        locked_q;
    logic        meas_valid_q;
    logic [31:0] half_period_q;
    logic        err_q;
    logic        stall_q;

    logic        edge_det;
    logic [3:0]  hit;
    logic        match;
    logic [1:0]  cls;
    logic [3:0]  next_cnt;

    assign edge_det = sync2_q ^ prev_q;

    assign hit[0] = (count_q >= LO0) && (count_q <= HI0);
    assign hit[1] = (count_q >= LO1) && (count_q <= HI1);
    assign hit[2] = (count_q >= LO2) && (count_q <= HI2);
    assign hit[3] = (count_q >= LO3) && (count_q <= HI3);

    // NOTE: every always_comb output gets a default first, otherwise paths that
    // skip an assignment would infer a latch.
    always_comb begin
        match = 1'b0;
        cls   = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) begin
                match = 1'b1;
                cls   = 2'(k);
            end
        end
    end

    always_comb begin
        next_cnt = 4'd1;
        if ((cls == cand_q) && (match_cnt_q != 4'd0)) begin
            next_cnt = (match_cnt_q >= CONF) ? CONF : match_cnt_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SEEK;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            count_q       <= 32'd0;
            cand_q        <= 2'b00;
            match_cnt_q   <= 4'd0;
            spe_q         <= 2'b00;
            locked_q      <= 1'b0;
            meas_valid_q  <= 1'b0;
            half_period_q <= 32'd0;
            err_q         <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            sync1_q      <= bus.spd_clk;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            meas_valid_q <= 1'b0;
            err_q        <= 1'b0;

            case (state_q)
                SEEK: begin
                    if (edge_det) begin
                        state_q <= MEAS;
                        count_q <= 32'd1;
                        stall_q <= 1'b0;
                    end
                end

                MEAS: begin
                    // An edge wins over a timeout landing in the same cycle.
                    if (edge_det) begin
                        count_q       <= 32'd1;
                        meas_valid_q  <= 1'b1;
                        half_period_q <= count_q;
                        if (match) begin
                            cand_q      <= cls;
                            match_cnt_q <= next_cnt;
                            if (next_cnt == CONF) begin
                                spe_q    <= cls;
                                locked_q <= 1'b1;
                            end else if (cls != spe_q) begin
                                locked_q <= 1'b0;
                            end
                        end else begin
                            err_q       <= 1'b1;
                            match_cnt_q <= 4'd0;
                            locked_q    <= 1'b0;
                        end
                    end else if (count_q >= TMO) begin
                        state_q     <= SEEK;
                        count_q     <= 32'd0;
                        stall_q     <= 1'b1;
                        locked_q    <= 1'b0;
                        match_cnt_q <= 4'd0;
                    end else begin
                        count_q <= count_q + 32'd1;
                    end
                end

                default: state_q <= SEEK;
            endcase
        end
    end

    assign bus.spe_out     = spe_q;
    assign bus.locked      = locked_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.half_period = half_period_q;
    assign bus.err         = err_q;
    assign bus.stall       = stall_q;

endmodule

// File: tb/tb_speed_detector.sv
// Directed bench for speed_detector with shrunk half-periods so locking,
// tolerance edges, stall and mid-measurement reset fit in a short run.
module tb_speed_detector;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    speed_detector_if bus ();

    speed_detector #(
        .HP0     (100),
        .HP1     (50),
        .HP2     (25),
        .HP3     (12),
        .TOL     (2),
        .CONFIRM (2),
        .TIMEOUT (200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".spe"},   32'(bus.spe_out),     32'd0);
        check({tag, ".lock"},  32'(bus.locked),      32'd0);
        check({tag, ".mv"},    32'(bus.meas_valid),  32'd0);
        check({tag, ".hp"},    bus.half_period,      32'd0);
        check({tag, ".err"},   32'(bus.err),         32'd0);
        check({tag, ".stall"}, 32'(bus.stall),       32'd0);
    endtask

    // Toggle spd_clk, check the registered result of this edge three negedges
    // later (2-FF sync + edge register), then wait until n cycles after the toggle.
    task automatic edge_chk(input int n, input logic exp_mv, input logic [31:0] exp_hp,
                            input logic [1:0] exp_spe, input logic exp_lock,
                            input logic exp_err, input logic exp_stall, input string tag);
        bus.spd_clk = ~bus.spd_clk;
        repeat (3) @(negedge clk);
        check({tag, ".mv"}, 32'(bus.meas_valid), 32'(exp_mv));
        if (exp_mv) check({tag, ".hp"}, bus.half_period, exp_hp);
        check({tag, ".spe"},   32'(bus.spe_out), 32'(exp_spe));
        check({tag, ".lock"},  32'(bus.locked),  32'(exp_lock));
        check({tag, ".err"},   32'(bus.err),     32'(exp_err));
        check({tag, ".stall"}, 32'(bus.stall),   32'(exp_stall));
        if (n > 3) begin
            @(negedge clk);
            check({tag, ".mv_end"},  32'(bus.meas_valid), 32'd0);
            check({tag, ".err_end"}, 32'(bus.err),        32'd0);
            repeat (n - 4) @(negedge clk);
        end
    endtask

    task automatic do_reset(input string tag);
        bus.spd_clk = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero({tag, ".in"});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero({tag, ".out"});
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.spd_clk = 1'b0;
        do_reset("rst0");

        // 2 Hz class: first edge silent, lock on the second 50-cycle measurement.
        edge_chk(50, 1'b0, 32'd0,  2'b00, 1'b0, 1'b0, 1'b0, "e1_first");
        edge_chk(50, 1'b1, 32'd50, 2'b00, 1'b0, 1'b0, 1'b0, "e2_hp50");
        edge_chk(12, 1'b1, 32'd50, 2'b01, 1'b1, 1'b0, 1'b0, "e3_lock01");

        // Switch to 8 Hz: lock drops at once, spe_out held until confirmed.
        edge_chk(12, 1'b1, 32'd12, 2'b01, 1'b0, 1'b0, 1'b0, "e4_drop");
        edge_chk(98, 1'b1, 32'd12, 2'b11, 1'b1, 1'b0, 1'b0, "e5_lock11");

        // Tolerance window limits 98/102 match class 0; 97 matches nothing.
        edge_chk(102, 1'b1, 32'd98,  2'b11, 1'b0, 1'b0, 1'b0, "e6_lo_edge");
        edge_chk(97,  1'b1, 32'd102, 2'b00, 1'b1, 1'b0, 1'b0, "e7_hi_edge");
        edge_chk(25,  1'b1, 32'd97,  2'b00, 1'b0, 1'b1, 1'b0, "e8_err97");

        // Lock at 10, then hold spd_clk to force a stall.
        edge_chk(25, 1'b1, 32'd25, 2'b00, 1'b0, 1'b0, 1'b0, "e9_hp25");
        edge_chk(3,  1'b1, 32'd25, 2'b10, 1'b1, 1'b0, 1'b0, "e10_lock10");
        repeat (199) @(negedge clk);
        check("stall_pre.stall", 32'(bus.stall),  32'd0);
        check("stall_pre.lock",  32'(bus.locked), 32'd1);
        @(negedge clk);
        check("stall.stall", 32'(bus.stall),      32'd1);
        check("stall.lock",  32'(bus.locked),     32'd0);
        check("stall.spe",   32'(bus.spe_out),    32'd2);
        check("stall.mv",    32'(bus.meas_valid), 32'd0);
        repeat (10) @(negedge clk);
        check("stall_hold.stall", 32'(bus.stall), 32'd1);

        // Resume at 25: stall clears on first edge, relock after two more.
        edge_chk(25, 1'b0, 32'd0,  2'b10, 1'b0, 1'b0, 1'b0, "e11_resume");
        edge_chk(25, 1'b1, 32'd25, 2'b10, 1'b0, 1'b0, 1'b0, "e12_hp25");
        edge_chk(3,  1'b1, 32'd25, 2'b10, 1'b1, 1'b0, 1'b0, "e13_relock");

        // Between classes: every measurement errors, spe_out stays at reset value.
        do_reset("rst1");
        edge_chk(37, 1'b0, 32'd0,  2'b00, 1'b0, 1'b0, 1'b0, "f1_first");
        edge_chk(37, 1'b1, 32'd37, 2'b00, 1'b0, 1'b1, 1'b0, "f2_err37");
        edge_chk(12, 1'b1, 32'd37, 2'b00, 1'b0, 1'b1, 1'b0, "f3_err37");

        // Lock at 11, then reset asynchronously partway through a measurement.
        edge_chk(12, 1'b1, 32'd12, 2'b00, 1'b0, 1'b0, 1'b0, "f4_hp12");
        edge_chk(3,  1'b1, 32'd12, 2'b11, 1'b1, 1'b0, 1'b0, "f5_lock11");
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        bus.spd_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("post_rst");

        // Partial count is gone: first edge silent, next measures a fresh 20.
        edge_chk(20, 1'b0, 32'd0,  2'b00, 1'b0, 1'b0, 1'b0, "g1_first");
        edge_chk(3,  1'b1, 32'd20, 2'b00, 1'b0, 1'b1, 1'b0, "g2_hp20");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
